// File: rtl/ddr2_rd_dma.sv
// DDR2 read DMA: issues read commands to an arbiter port, reassembles the
// two 128-bit read beats of each command into a 256-bit word, and buffers
// the words in a fall-through FIFO for the consumer. Issue is throttled by
// a credit (in-flight commands plus buffered words) so the FIFO never
// overflows.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing commands while credit allows
// DRAIN  | all commands issued, waiting for the consumer to take every word
// FINISH | one-cycle done pulse
module ddr2_rd_dma #(
  parameter int          DEPTH     = 16,
  parameter logic [30:0] ADDR_STEP = 31'd4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [30:0]  base_addr,
  input  logic [15:0]  len,
  output logic         busy,
  output logic         done,
  output logic         req,
  input  logic         ack,
  output logic [30:0]  addr,
  output logic         read,
  output logic         fin,
  output logic [255:0] data_i,
  output logic [31:0]  mask,
  input  logic         valid,
  input  logic [127:0] data_o,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [255:0] rd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ONE_CW  = 1;
  localparam logic [PW-1:0] ONE_PW  = 1;
  localparam logic [CW:0]   ONE_CR  = 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t         state_q, state_d;
  logic [15:0]    cmd_left_q, cmd_left_d;
  logic [15:0]    word_left_q, word_left_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW:0]    credit, credit_d;
  logic [30:0]    addr_q;
  logic           req_q, req_d;
  logic           toggle_q;
  logic [127:0]   lo_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [255:0]   mem [DEPTH];
  logic           start_acc, ack_acc, beat_acc, push, pop;

  assign start_acc = start && (state_q == IDLE);
  assign ack_acc   = ack && req_q && (cmd_left_q != 16'd0);
  assign beat_acc  = valid && (outstanding_q != '0);
  assign push      = beat_acc && toggle_q;
  assign pop       = rd_valid && rd_ready;
  assign credit    = {1'b0, outstanding_q} + {1'b0, count_q};

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign req      = req_q;
  assign addr     = addr_q;
  assign fin      = req_q && ((cmd_left_q == 16'd1) || ((credit + ONE_CR) >= DEPTH_C));
  assign read     = 1'b1;
  assign data_i   = '0;
  assign mask     = '0;
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem[rd_ptr_q];

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == 16'd0) ? FINISH : ISSUE;
      ISSUE:   if (cmd_left_q == 16'd0) state_d = DRAIN;
      DRAIN:   if (word_left_q == 16'd0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the counters and of req; req looks ahead so it rises
  // on the cycle right after start and drops as soon as credit runs out.
  always_comb begin
    cmd_left_d    = cmd_left_q;
    word_left_d   = word_left_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    if (start_acc) begin
      cmd_left_d  = len;
      word_left_d = len;
    end else begin
      if (ack_acc) cmd_left_d  = cmd_left_q - 16'd1;
      if (pop)     word_left_d = word_left_q - 16'd1;
    end
    case ({ack_acc, push})
      2'b10:   outstanding_d = outstanding_q + ONE_CW;
      2'b01:   outstanding_d = outstanding_q - ONE_CW;
      default: outstanding_d = outstanding_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CW;
      2'b01:   count_d = count_q - ONE_CW;
      default: count_d = count_q;
    endcase
    credit_d = {1'b0, outstanding_d} + {1'b0, count_d};
    req_d    = (state_d == ISSUE) && (cmd_left_d != 16'd0) && (credit_d < DEPTH_C)
               && !(ack_acc && fin);
  end

  // Control and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_left_q    <= '0;
      word_left_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      req_q         <= 1'b0;
      toggle_q      <= 1'b0;
      lo_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      cmd_left_q    <= cmd_left_d;
      word_left_q   <= word_left_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      req_q         <= req_d;
      if (start_acc)    addr_q <= base_addr;
      else if (ack_acc) addr_q <= addr_q + ADDR_STEP;
      if (beat_acc) begin
        toggle_q <= ~toggle_q;
        if (!toggle_q) lo_q <= data_o;
      end
      if (push) wr_ptr_q <= wr_ptr_q + ONE_PW;
      if (pop)  rd_ptr_q <= rd_ptr_q + ONE_PW;
    end
  end

  // Buffer storage; emptiness is tracked by count, so no reset needed here
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= {data_o, lo_q};
  end

endmodule

// File: tb/tb_ddr2_rd_dma.sv
// Testbench for ddr2_rd_dma: an arbiter/memory responder returns two beats
// per acked command with data derived from the acked address, and a
// scoreboard compares every word the consumer takes against the words the
// bench expects from its own address model.
module tb_ddr2_rd_dma;

  logic         CLK, RST;
  logic         start;
  logic [30:0]  base_addr;
  logic [15:0]  len;
  logic         busy, done, req, ack, read, fin;
  logic [30:0]  addr;
  logic [255:0] data_i;
  logic [31:0]  mask;
  logic         valid;
  logic [127:0] data_o;
  logic         rd_valid, rd_ready;
  logic [255:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [30:0]  ack_addr_q[$];
  logic         ack_fin_q[$];
  logic [30:0]  pend[$];
  logic [255:0] exp_q[$];
  int           words, done_cnt, cyc, done_cyc, start_cyc;
  bit           req_seen;
  int           rphase;

  ddr2_rd_dma dut (
    .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .req(req), .ack(ack), .addr(addr), .read(read),
    .fin(fin), .data_i(data_i), .mask(mask), .valid(valid), .data_o(data_o),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [255:0] word_of(input logic [30:0] a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = {1'b0, a} ^ (32'h9E3779B9 * 32'(i + 1));
    return w;
  endfunction

  // Monitor and scoreboard, sampling on the falling edge
  initial begin
    cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        if (req) req_seen = 1'b1;
        if (req && ack) begin
          ack_addr_q.push_back(addr);
          ack_fin_q.push_back(fin);
          pend.push_back(addr);
        end
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (rd_valid && rd_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL word_unexpected: got %h, no word expected", rd_data);
          end else begin
            logic [255:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
              n_fail++;
              $display("FAIL rd_data: got %h expected %h", rd_data, e);
            end
          end
          words++;
        end
      end
    end
  end

  // Memory responder: two beats per acked command, low half first
  initial begin
    logic [255:0] cur;
    valid  = 1'b0;
    data_o = '0;
    rphase = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (rphase == 0) begin
        if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          cur    = word_of(pend[0]);
          valid  = 1'b1;
          data_o = cur[127:0];
          rphase = 1;
        end else begin
          valid = 1'b0;
        end
      end else begin
        valid  = 1'b1;
        data_o = cur[255:128];
        void'(pend.pop_front());
        rphase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    ack_addr_q.delete();
    ack_fin_q.delete();
    exp_q.delete();
    words    = 0;
    done_cnt = 0;
    done_cyc = -1;
    req_seen = 1'b0;
  endtask

  task automatic expect_words(input logic [30:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(word_of(b + 31'(4 * i)));
  endtask

  task automatic launch(input logic [30:0] b, input logic [15:0] n);
    tick();
    base_addr = b;
    len       = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < budget);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (req !== 1'b0)      begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
    n_checks++; if (fin !== 1'b0)      begin n_fail++; $display("FAIL reset_fin: got %b expected 0", fin); end
    n_checks++; if (addr !== 31'd0)    begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (read !== 1'b1)     begin n_fail++; $display("FAIL tie_read: got %b expected 1", read); end
    n_checks++; if (data_i !== 256'd0) begin n_fail++; $display("FAIL tie_data_i: got %h expected 0", data_i); end
    n_checks++; if (mask !== 32'd0)    begin n_fail++; $display("FAIL tie_mask: got %h expected 0", mask); end
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_logs();
    ack      = 1'b1;
    rd_ready = 1'b1;
    expect_words(31'h100, 3);
    launch(31'h100, 16'd3);
    @(negedge CLK);
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL basic_req_latency: got %b expected 1", req); end
    wait_idle(200, "basic");
    n_checks++; if (words != 3)        begin n_fail++; $display("FAIL basic_words: got %0d expected 3", words); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_left: got %0d expected 0", exp_q.size()); end
    n_checks++; if (done_cnt != 1)     begin n_fail++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
    n_checks++;
    if (ack_addr_q.size() != 3) begin
      n_fail++; $display("FAIL basic_acks: got %0d expected 3", ack_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (ack_addr_q[i] !== 31'(32'h100 + 4 * i)) begin
          n_fail++; $display("FAIL basic_ack_addr%0d: got %h expected %h", i, ack_addr_q[i], 32'h100 + 4 * i);
        end
        n_checks++;
        if (ack_fin_q[i] !== (i == 2)) begin
          n_fail++; $display("FAIL basic_ack_fin%0d: got %b expected %b", i, ack_fin_q[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    clear_logs();
    ack      = 1'b1;
    rd_ready = 1'b0;
    expect_words(31'h2000, 40);
    launch(31'h2000, 16'd40);
    repeat (80) @(negedge CLK);
    n_checks++; if (ack_addr_q.size() != 16) begin n_fail++; $display("FAIL bp_acks: got %0d expected 16", ack_addr_q.size()); end
    n_checks++; if (req !== 1'b0)      begin n_fail++; $display("FAIL bp_req: got %b expected 0", req); end
    n_checks++; if (addr !== 31'h2040) begin n_fail++; $display("FAIL bp_addr: got %h expected 2040", addr); end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rd_valid: got %b expected 1", rd_valid); end
    if (ack_fin_q.size() >= 16) begin
      n_checks++; if (ack_fin_q[15] !== 1'b1) begin n_fail++; $display("FAIL bp_fin16: got %b expected 1", ack_fin_q[15]); end
      n_checks++; if (ack_fin_q[14] !== 1'b0) begin n_fail++; $display("FAIL bp_fin15: got %b expected 0", ack_fin_q[14]); end
    end
  endtask

  task automatic test_resume();
    tick();
    rd_ready = 1'b1;
    wait_idle(800, "resume");
    n_checks++; if (ack_addr_q.size() != 40) begin n_fail++; $display("FAIL resume_acks: got %0d expected 40", ack_addr_q.size()); end
    n_checks++; if (words != 40)       begin n_fail++; $display("FAIL resume_words: got %0d expected 40", words); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL resume_left: got %0d expected 0", exp_q.size()); end
    n_checks++; if (done_cnt != 1)     begin n_fail++; $display("FAIL resume_done: got %0d expected 1", done_cnt); end
    if (ack_addr_q.size() == 40) begin
      n_checks++;
      if (ack_addr_q[39] !== 31'h209C) begin n_fail++; $display("FAIL resume_last_addr: got %h expected 209c", ack_addr_q[39]); end
    end
  endtask

  task automatic test_len0();
    clear_logs();
    ack = 1'b1;
    launch(31'h500, 16'd0);
    repeat (6) @(negedge CLK);
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL len0_done: got %0d expected 1", done_cnt); end
    n_checks++; if (req_seen)      begin n_fail++; $display("FAIL len0_req: got 1 expected 0"); end
    n_checks++;
    if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
      n_fail++; $display("FAIL len0_latency: got %0d expected 1..2", done_cyc - start_cyc);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    clear_logs();
    ack      = 1'b1;
    rd_ready = 1'b1;
    exp_q.push_back(word_of(31'h7FFFFFFC));
    exp_q.push_back(word_of(31'h0));
    launch(31'h7FFFFFFC, 16'd2);
    wait_idle(200, "wrap");
    n_checks++; if (words != 2) begin n_fail++; $display("FAIL wrap_words: got %0d expected 2", words); end
    n_checks++;
    if (ack_addr_q.size() != 2) begin
      n_fail++; $display("FAIL wrap_acks: got %0d expected 2", ack_addr_q.size());
    end else begin
      n_checks++; if (ack_addr_q[0] !== 31'h7FFFFFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h expected 7ffffffc", ack_addr_q[0]); end
      n_checks++; if (ack_addr_q[1] !== 31'h0)        begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0", ack_addr_q[1]); end
    end
  endtask

  task automatic test_start_ignored_and_abort();
    int n;
    clear_logs();
    ack      = 1'b1;
    rd_ready = 1'b1;
    expect_words(31'h300, 8);
    launch(31'h300, 16'd8);
    base_addr = 31'h900;
    len       = 16'd2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    n = 0;
    while (ack_addr_q.size() < 5 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    n_checks++; if (ack_addr_q.size() != 5) begin n_fail++; $display("FAIL abort_acks: got %0d expected 5", ack_addr_q.size()); end
    if (ack_addr_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (ack_addr_q[i] !== 31'(32'h300 + 4 * i)) begin
          n_fail++; $display("FAIL ignored_start_addr%0d: got %h expected %h", i, ack_addr_q[i], 32'h300 + 4 * i);
        end
      end
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (req !== 1'b0)      begin n_fail++; $display("FAIL abort_req: got %b expected 0", req); end
    n_checks++; if (fin !== 1'b0)      begin n_fail++; $display("FAIL abort_fin: got %b expected 0", fin); end
    n_checks++; if (addr !== 31'd0)    begin n_fail++; $display("FAIL abort_addr: got %h expected 0", addr); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
    repeat (2) tick();
    RST = 1'b1;
    n = 0;
    while ((pend.size() != 0 || rphase != 0) && n < 80) begin
      tick();
      n++;
    end
    repeat (3) @(negedge CLK);
    n_checks++; if (pend.size() != 0)  begin n_fail++; $display("FAIL abort_drain: got %0d pending expected 0", pend.size()); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL abort_dropped: rd_valid got %b expected 0", rd_valid); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort_idle: busy got %b expected 0", busy); end
    clear_logs();
    expect_words(31'h400, 4);
    launch(31'h400, 16'd4);
    wait_idle(200, "restart");
    n_checks++; if (words != 4)        begin n_fail++; $display("FAIL restart_words: got %0d expected 4", words); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_left: got %0d expected 0", exp_q.size()); end
    n_checks++; if (done_cnt != 1)     begin n_fail++; $display("FAIL restart_done: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    RST       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    ack       = 1'b0;
    rd_ready  = 1'b0;
    clear_logs();
    test_reset();
    test_basic();
    test_back_pressure();
    test_resume();
    test_len0();
    test_wrap();
    test_start_ignored_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
